// File: rtl/lcd_sprite_animator_if.sv
// LCD bus and pattern-ROM port bundle for the sprite animator.
// The animator is the master: it drives the panel bus and the ROM address
// and consumes the combinational ROM byte.
interface lcd_sprite_animator_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] ROM_ADDR;
   logic [7:0]        ROM_DATA;
   logic [7:0]        LCD_DATA;
   logic              LCD_ENABLE;
   logic              LCD_RW;
   logic              LCD_RSTN;
   logic              LCD_CS1;
   logic              LCD_CS2;
   logic              LCD_DI;

   modport master (
      output ROM_ADDR,
      input  ROM_DATA,
      output LCD_DATA, LCD_ENABLE, LCD_RW, LCD_RSTN, LCD_CS1, LCD_CS2, LCD_DI
   );

   modport slave (
      input  ROM_ADDR,
      output ROM_DATA,
      input  LCD_DATA, LCD_ENABLE, LCD_RW, LCD_RSTN, LCD_CS1, LCD_CS2, LCD_DI
   );
endinterface

// File: rtl/lcd_sprite_animator.sv
// KS0108-style 128x64 GLCD sprite animator. Clears both chips, then draws a
// multi-frame sprite from a pattern ROM, moving it STEP columns per frame
// with wrap-around and trail erase. Two stages: p0 sequences transactions
// and presents ROM_ADDR; p1 registers the bus byte (ROM byte or command).
module lcd_sprite_animator #(
   parameter int SPR_W        = 16,
   parameter int SPR_PAGES    = 2,
   parameter int FRAMES       = 3,
   parameter int START_PAGE   = 3,
   parameter int START_X      = 0,
   parameter int STEP         = 1,
   parameter int PAUSE_CYCLES = 32768,
   parameter int ADDR_W       = 8
) (
   input  logic LCD_CLK,
   input  logic RESETN,
   input  logic RUN,
   input  logic DIR,
   output logic BUSY,
   output logic FRAME_DONE,
   lcd_sprite_animator_if.master lcd
);

   localparam logic [2:0] S_INIT  = 3'd0;
   localparam logic [2:0] S_LINE  = 3'd1;
   localparam logic [2:0] S_CLEAR = 3'd2;
   localparam logic [2:0] S_DRAW  = 3'd3;
   localparam logic [2:0] S_PAUSE = 3'd4;

   localparam logic [1:0] PH_PAGE = 2'd0;
   localparam logic [1:0] PH_Y    = 2'd1;
   localparam logic [1:0] PH_DATA = 2'd2;

   localparam int SPAN     = SPR_W + STEP;
   localparam int FRAME_SZ = SPR_PAGES * SPR_W;
   localparam int PC_W     = $clog2(PAUSE_CYCLES);
   localparam logic [PC_W-1:0] PC_LOAD = PC_W'(PAUSE_CYCLES - 1);

   function automatic logic [7:0] set_page_cmd(input logic [2:0] page);
      return {5'b10111, page};
   endfunction

   function automatic logic [7:0] set_y_cmd(input logic [5:0] y);
      return {2'b01, y};
   endfunction

   logic [2:0]        state_q;
   logic [6:0]        x_q;
   logic [1:0]        frame_q;
   logic              last_dir_q;
   logic [PC_W-1:0]   pcnt_q;
   logic [2:0]        cpage_q;
   logic [6:0]        ccnt_q;
   logic [2:0]        row_q;
   logic [5:0]        idx_q;
   logic [1:0]        ph_q;

   logic              vld_p0, di_p0, cs1_p0, cs2_p0, rom_sel_p0, fdone_p0;
   logic [7:0]        byte_p0;
   logic [ADDR_W-1:0] rom_addr_p0;

   logic              vld_p1, di_p1, cs1_p1, cs2_p1, fdone_p1, busy_p1;
   logic [7:0]        data_p1;

   logic [6:0]        base_col, cur_col, nxt_col;
   logic [5:0]        spr_col;
   logic              spr_hit, last_col, last_row;
   logic [2:0]        page_abs;
   logic [ADDR_W-1:0] spr_addr;

   // Column geometry of the current draw position
   always_comb begin
      base_col = last_dir_q ? x_q : x_q - 7'(STEP);
      cur_col  = base_col + {1'b0, idx_q};
      nxt_col  = cur_col + 7'd1;
      spr_col  = last_dir_q ? idx_q : idx_q - 6'(STEP);
      spr_hit  = last_dir_q ? (idx_q < 6'(SPR_W)) : (idx_q >= 6'(STEP));
      last_col = (idx_q == 6'(SPAN - 1));
      last_row = (row_q == 3'(SPR_PAGES - 1));
      page_abs = 3'(START_PAGE) + row_q;
      spr_addr = spr_hit ? (ADDR_W'(frame_q) * ADDR_W'(FRAME_SZ)
                            + ADDR_W'(row_q) * ADDR_W'(SPR_W)
                            + ADDR_W'(spr_col)) : '0;
   end

   // p0: control FSM, transaction sequencing and ROM address
   always_ff @(posedge LCD_CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q     <= S_INIT;
         x_q         <= 7'(START_X);
         frame_q     <= 2'd0;
         last_dir_q  <= 1'b0;
         pcnt_q      <= PC_LOAD;
         cpage_q     <= 3'd0;
         ccnt_q      <= 7'd0;
         row_q       <= 3'd0;
         idx_q       <= 6'd0;
         ph_q        <= PH_PAGE;
         vld_p0      <= 1'b0;
         di_p0       <= 1'b0;
         cs1_p0      <= 1'b0;
         cs2_p0      <= 1'b0;
         rom_sel_p0  <= 1'b0;
         fdone_p0    <= 1'b0;
         byte_p0     <= 8'h00;
         rom_addr_p0 <= '0;
      end else begin
         vld_p0      <= 1'b0;
         rom_sel_p0  <= 1'b0;
         fdone_p0    <= 1'b0;
         rom_addr_p0 <= '0;
         case (state_q)
            S_INIT: begin
               vld_p0  <= 1'b1;
               di_p0   <= 1'b0;
               cs1_p0  <= 1'b1;
               cs2_p0  <= 1'b1;
               byte_p0 <= 8'h3F;
               state_q <= S_LINE;
            end
            S_LINE: begin
               vld_p0  <= 1'b1;
               di_p0   <= 1'b0;
               cs1_p0  <= 1'b1;
               cs2_p0  <= 1'b1;
               byte_p0 <= 8'hC0;
               cpage_q <= 3'd0;
               ccnt_q  <= 7'd0;
               state_q <= S_CLEAR;
            end
            S_CLEAR: begin
               vld_p0 <= 1'b1;
               cs1_p0 <= 1'b1;
               cs2_p0 <= 1'b1;
               if (ccnt_q == 7'd0) begin
                  di_p0   <= 1'b0;
                  byte_p0 <= set_page_cmd(cpage_q);
               end else if (ccnt_q == 7'd1) begin
                  di_p0   <= 1'b0;
                  byte_p0 <= set_y_cmd(6'd0);
               end else begin
                  di_p0   <= 1'b1;
                  byte_p0 <= 8'h00;
               end
               if (ccnt_q == 7'd65) begin
                  ccnt_q <= 7'd0;
                  if (cpage_q == 3'd7) begin
                     row_q   <= 3'd0;
                     idx_q   <= 6'd0;
                     ph_q    <= PH_PAGE;
                     state_q <= S_DRAW;
                  end else begin
                     cpage_q <= cpage_q + 3'd1;
                  end
               end else begin
                  ccnt_q <= ccnt_q + 7'd1;
               end
            end
            S_DRAW: begin
               vld_p0 <= 1'b1;
               cs1_p0 <= ~cur_col[6];
               cs2_p0 <= cur_col[6];
               if (ph_q == PH_PAGE) begin
                  di_p0   <= 1'b0;
                  byte_p0 <= set_page_cmd(page_abs);
                  ph_q    <= PH_Y;
               end else if (ph_q == PH_Y) begin
                  di_p0   <= 1'b0;
                  byte_p0 <= set_y_cmd(cur_col[5:0]);
                  ph_q    <= PH_DATA;
               end else begin
                  di_p0       <= 1'b1;
                  byte_p0     <= 8'h00;
                  rom_sel_p0  <= spr_hit;
                  rom_addr_p0 <= spr_addr;
                  if (last_col) begin
                     idx_q <= 6'd0;
                     ph_q  <= PH_PAGE;
                     if (last_row) begin
                        row_q    <= 3'd0;
                        fdone_p0 <= 1'b1;
                        state_q  <= S_PAUSE;
                     end else begin
                        row_q <= row_q + 3'd1;
                     end
                  end else begin
                     idx_q <= idx_q + 6'd1;
                     if (nxt_col[5:0] == 6'd0) ph_q <= PH_PAGE;
                  end
               end
            end
            S_PAUSE: begin
               if (pcnt_q != '0) begin
                  pcnt_q <= pcnt_q - 1'b1;
               end else if (RUN) begin
                  x_q        <= DIR ? x_q - 7'(STEP) : x_q + 7'(STEP);
                  last_dir_q <= DIR;
                  frame_q    <= (frame_q == 2'(FRAMES - 1)) ? 2'd0 : frame_q + 2'd1;
                  pcnt_q     <= PC_LOAD;
                  state_q    <= S_DRAW;
               end
            end
            default: state_q <= S_INIT;
         endcase
      end
   end

   // p1: registered LCD bus, status outputs aligned with the bus
   always_ff @(posedge LCD_CLK or negedge RESETN) begin
      if (!RESETN) begin
         vld_p1   <= 1'b0;
         di_p1    <= 1'b0;
         cs1_p1   <= 1'b0;
         cs2_p1   <= 1'b0;
         data_p1  <= 8'h00;
         fdone_p1 <= 1'b0;
         busy_p1  <= 1'b1;
      end else begin
         vld_p1   <= vld_p0;
         fdone_p1 <= fdone_p0;
         busy_p1  <= (state_q != S_PAUSE);
         if (vld_p0) begin
            di_p1   <= di_p0;
            cs1_p1  <= cs1_p0;
            cs2_p1  <= cs2_p0;
            data_p1 <= rom_sel_p0 ? lcd.ROM_DATA : byte_p0;
         end
      end
   end

   assign lcd.ROM_ADDR   = rom_addr_p0;
   assign lcd.LCD_DATA   = data_p1;
   assign lcd.LCD_ENABLE = LCD_CLK & vld_p1;
   assign lcd.LCD_RW     = 1'b0;
   assign lcd.LCD_RSTN   = RESETN;
   assign lcd.LCD_CS1    = cs1_p1;
   assign lcd.LCD_CS2    = cs2_p1;
   assign lcd.LCD_DI     = di_p1;
   assign BUSY           = busy_p1;
   assign FRAME_DONE     = fdone_p1;

endmodule

// File: tb/tb_lcd_sprite_animator.sv
// Scoreboard bench for lcd_sprite_animator: stimulus pushes the expected
// LCD transactions, a monitor pops and compares every enabled bus cycle.
module tb_lcd_sprite_animator;

   localparam int SPR_W        = 16;
   localparam int SPR_PAGES    = 2;
   localparam int FRAMES       = 3;
   localparam int START_PAGE   = 3;
   localparam int START_X      = 120;
   localparam int STEP         = 1;
   localparam int PAUSE_CYCLES = 4;
   localparam int ADDR_W       = 8;
   localparam int SPAN         = SPR_W + STEP;

   logic LCD_CLK = 1'b0;
   logic RESETN  = 1'b1;
   logic RUN     = 1'b0;
   logic DIR     = 1'b0;
   logic BUSY;
   logic FRAME_DONE;

   lcd_sprite_animator_if #(.ADDR_W(ADDR_W)) lcd ();

   lcd_sprite_animator #(
      .SPR_W(SPR_W), .SPR_PAGES(SPR_PAGES), .FRAMES(FRAMES),
      .START_PAGE(START_PAGE), .START_X(START_X), .STEP(STEP),
      .PAUSE_CYCLES(PAUSE_CYCLES), .ADDR_W(ADDR_W)
   ) dut (
      .LCD_CLK(LCD_CLK),
      .RESETN(RESETN),
      .RUN(RUN),
      .DIR(DIR),
      .BUSY(BUSY),
      .FRAME_DONE(FRAME_DONE),
      .lcd(lcd)
   );

   always #5 LCD_CLK = ~LCD_CLK;

   // Pattern ROM: distinct non-zero byte per address
   function automatic logic [7:0] rom_byte(input logic [ADDR_W-1:0] a);
      return a + 8'h21;
   endfunction

   assign lcd.ROM_DATA = rom_byte(lcd.ROM_ADDR);

   logic [10:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int fd_cnt   = 0;
   int txn_n    = 0;
   int bx, bfr;
   bit bld;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
   endtask

   function automatic void push(input bit c1, input bit c2, input bit di, input logic [7:0] d);
      exp_q.push_back({c1, c2, di, d});
   endfunction

   function automatic void push_boot();
      push(1, 1, 0, 8'h3F);
      push(1, 1, 0, 8'hC0);
      for (int p = 0; p < 8; p++) begin
         push(1, 1, 0, 8'(8'hB8 + p));
         push(1, 1, 0, 8'h40);
         for (int c = 0; c < 64; c++) push(1, 1, 1, 8'h00);
      end
   endfunction

   function automatic void push_frame(input int x, input bit ld, input int fr);
      int start, c, sc;
      bit c1, spr;
      logic [7:0] d;
      for (int r = 0; r < SPR_PAGES; r++) begin
         start = ld ? x : (x - STEP + 128) % 128;
         for (int i = 0; i < SPAN; i++) begin
            c  = (start + i) % 128;
            c1 = (c < 64);
            if (i == 0 || c % 64 == 0) begin
               push(c1, !c1, 0, 8'(8'hB8 + START_PAGE + r));
               push(c1, !c1, 0, 8'(8'h40 + c % 64));
            end
            spr = ld ? (i < SPR_W) : (i >= STEP);
            sc  = ld ? i : i - STEP;
            d   = spr ? rom_byte(ADDR_W'(fr * SPR_PAGES * SPR_W + r * SPR_W + sc)) : 8'h00;
            push(c1, !c1, 1, d);
         end
      end
   endfunction

   // Monitor: compare each enabled bus cycle against the scoreboard
   initial begin
      logic [10:0] got, want;
      forever begin
         @(posedge LCD_CLK);
         #1;
         if (FRAME_DONE) fd_cnt++;
         if (lcd.LCD_ENABLE) begin
            got = {lcd.LCD_CS1, lcd.LCD_CS2, lcd.LCD_DI, lcd.LCD_DATA};
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_txn%0d: got 0x%0h, expected no transaction", txn_n, got);
            end else begin
               want = exp_q.pop_front();
               chk($sformatf("txn%0d", txn_n), 32'(got), 32'(want));
            end
            txn_n++;
         end
      end
   end

   task automatic check_reset(input string nm);
      chk({nm, "_data"},   32'(lcd.LCD_DATA),   32'h0);
      chk({nm, "_di"},     32'(lcd.LCD_DI),     32'h0);
      chk({nm, "_cs1"},    32'(lcd.LCD_CS1),    32'h0);
      chk({nm, "_cs2"},    32'(lcd.LCD_CS2),    32'h0);
      chk({nm, "_en"},     32'(lcd.LCD_ENABLE), 32'h0);
      chk({nm, "_rw"},     32'(lcd.LCD_RW),     32'h0);
      chk({nm, "_rstn"},   32'(lcd.LCD_RSTN),   32'h0);
      chk({nm, "_addr"},   32'(lcd.ROM_ADDR),   32'h0);
      chk({nm, "_busy"},   32'(BUSY),           32'h1);
      chk({nm, "_fdone"},  32'(FRAME_DONE),     32'h0);
   endtask

   task automatic wait_frame(input string nm);
      int k = 0;
      while (k < 3000 && !FRAME_DONE) begin
         @(posedge LCD_CLK);
         #1;
         k++;
      end
      chk({nm, "_done_seen"}, 32'(FRAME_DONE), 32'h1);
      @(posedge LCD_CLK);
      #1;
      chk({nm, "_pulse_end"}, 32'(FRAME_DONE), 32'h0);
      chk({nm, "_busy_low"}, 32'(BUSY), 32'h0);
      chk({nm, "_drained"}, 32'(exp_q.size()), 32'h0);
      exp_q.delete();
   endtask

   task automatic model_reset();
      bx  = START_X;
      bld = 0;
      bfr = 0;
   endtask

   task automatic frame_step(input bit dir);
      DIR = dir;
      bx  = dir ? (bx - STEP + 128) % 128 : (bx + STEP) % 128;
      bld = dir;
      bfr = (bfr + 1 == FRAMES) ? 0 : bfr + 1;
      push_frame(bx, bld, bfr);
      RUN = 1'b1;
      wait_frame($sformatf("frame_x%0d_d%0d", bx, dir));
   endtask

   initial begin
      int fd_before, k;
      #3 RESETN = 1'b0;
      repeat (3) @(posedge LCD_CLK);
      #1;
      check_reset("por");

      model_reset();
      push_boot();
      push_frame(bx, bld, bfr);
      @(negedge LCD_CLK) RESETN = 1'b1;
      wait_frame("first_frame");

      // RUN=0: frozen in PAUSE, no traffic, no further FRAME_DONE
      fd_before = fd_cnt;
      repeat (20) @(posedge LCD_CLK);
      #1;
      chk("freeze_no_frame", 32'(fd_cnt - fd_before), 32'h0);
      chk("freeze_busy", 32'(BUSY), 32'h0);

      // Right across the 127->0 wrap and on to the chip boundary
      for (int f = 0; f < 58; f++) frame_step(1'b0);
      chk("model_x_at_boundary", 32'(bx), 32'd50);

      // Direction reversal and back
      frame_step(1'b1);
      frame_step(1'b1);
      frame_step(1'b0);

      // Reset in the middle of DRAW
      DIR = 1'b1;
      bx  = (bx - STEP + 128) % 128;
      bld = 1;
      bfr = (bfr + 1 == FRAMES) ? 0 : bfr + 1;
      push_frame(bx, bld, bfr);
      k = 0;
      while (k < 500 && exp_q.size() >= 20) begin
         @(posedge LCD_CLK);
         #1;
         k++;
      end
      chk("mid_draw_reached", 32'(exp_q.size() < 20), 32'h1);
      #2 RESETN = 1'b0;
      #1 check_reset("mid_reset");
      exp_q.delete();
      RUN = 1'b0;
      DIR = 1'b0;
      repeat (3) @(posedge LCD_CLK);
      model_reset();
      push_boot();
      push_frame(bx, bld, bfr);
      @(negedge LCD_CLK) RESETN = 1'b1;
      wait_frame("restart_frame");

      chk("frame_done_total", 32'(fd_cnt), 32'd63);
      repeat (5) @(posedge LCD_CLK);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lcd_sprite_animator.md
Name: lcd_sprite_animator

Overview:
- Parametrised KS0108-style GLCD sprite animator.
- Drives a 128x64 panel made of two 64-column chips (CS1 = columns 0-63, CS2 = columns 64-127).
- Clears the screen, then repeatedly draws a multi-frame sprite from an external pattern ROM, moving it STEP columns per frame, with wrap-around across the chip boundary and the screen edge, and erasing its trail.
- Replaces the single-chip fixed-position animators in the LCD lab designs.

Parameters:
- SPR_W, 16: sprite width in columns, 1..48.
- SPR_PAGES, 2: sprite height in 8-row pages, 1..8.
- FRAMES, 3: number of animation frames, 1..4.
- START_PAGE, 3: top page of the sprite. START_PAGE+SPR_PAGES must be <=8.
- START_X, 0: initial absolute column, 0..127.
- STEP, 1: columns moved per frame, 1..15. Also the number of erase columns.
- PAUSE_CYCLES, 32768: clocks spent in PAUSE per frame, >=2.
- ADDR_W, 8: ROM address width. Must satisfy 2^ADDR_W >= FRAMES*SPR_PAGES*SPR_W.

Ports:
- LCD_CLK  in  1  system clock; LCD bus timing reference.
- RESETN  in  1  asynchronous active-low reset.
- RUN  in  1  1 = animate; 0 = freeze in PAUSE after the current frame.
- DIR  in  1  0 = move right (+STEP); 1 = move left (-STEP). Sampled at pause end.
- ROM_ADDR  out  ADDR_W  pattern address = frame*SPR_PAGES*SPR_W + page*SPR_W + col.
- ROM_DATA  in  8  pattern byte. Combinational ROM, valid in the same cycle as ROM_ADDR.
- LCD_DATA  out  8  command/data byte.
- LCD_ENABLE  out  1  LCD_CLK AND en_reg (write strobe; LCD latches on falling edge).
- LCD_RW  out  1  always 0 (write only).
- LCD_RSTN  out  1  equal to RESETN.
- LCD_CS1, LCD_CS2  out  1  chip selects, active-high.
- LCD_DI  out  1  0 = instruction, 1 = data.
- BUSY  out  1  1 in every state except PAUSE.
- FRAME_DONE  out  1  one-cycle pulse on entry to PAUSE.

Behaviour:
- Reset (async, RESETN=0):
  - State INIT.
  - LCD_DATA=0, LCD_DI=0, LCD_RW=0, CS1=0, CS2=0, en_reg=0, FRAME_DONE=0, BUSY=1.
  - x=START_X, frame=0, last_dir=0, pause counter=PAUSE_CYCLES-1.
  - Reset mid-operation aborts any sequence; the next run restarts with INIT.
- All outputs except LCD_ENABLE and LCD_RSTN are registered. One LCD transaction per clock; en_reg=1 only in cycles that carry a transaction.
- INIT: issue 0x3F (display on) with CS1=CS2=1 -> START_LINE.
- START_LINE: issue 0xC0 with CS1=CS2=1 -> CLEAR.
- CLEAR: both chips selected. For each page p=0..7: {10111,p}, then 0x40, then 64 data writes of 0x00. After page 7 -> DRAW. Total 528 transactions.
- DRAW: draw span of SPR_W+STEP columns.
  - last_dir=0: span starts at x-STEP (mod 128). The first STEP bytes are 0x00 (erase); the next SPR_W bytes are ROM_DATA.
  - last_dir=1: span starts at x. SPR_W ROM bytes, then STEP bytes of 0x00.
  - First frame after CLEAR uses last_dir=0; its erase columns are already blank.
  - Per page row (START_PAGE..START_PAGE+SPR_PAGES-1):
    - Issue set-page {10111,page}, then set-Y {01,col[5:0]}, both with CS = chip of the current absolute column (col[6]=0 -> CS1 only, 1 -> CS2 only).
    - Whenever the next column's col[5:0]==0 mid-row (chip boundary or 127->0 wrap), re-issue set-page and set-Y to the newly selected chip before its data byte.
    - Column arithmetic is 7-bit modulo 128.
  - After the last page: FRAME_DONE pulse -> PAUSE.
- PAUSE:
  - Counter decrements to 0 and holds at 0.
  - When counter==0 and RUN=1: x = x+STEP (DIR=0) or x-STEP (DIR=1), mod 128; last_dir=DIR; frame = (frame+1 == FRAMES) ? 0 : frame+1; counter reloads PAUSE_CYCLES-1 -> DRAW.
  - When counter==0 and RUN=0: remain in PAUSE, nothing changes.
- A direction reversal erases on the new trailing side. The old trailing column was already blank.
- ROM_ADDR is driven only for sprite columns; otherwise it is 0.

Test Plan:
- Reset release, RUN=0: first transactions are 0x3F (CS1=CS2=1), 0xC0, 0xB8, 0x40, then 64x 0x00. CLEAR ends after 528 enabled cycles. Then one DRAW of frame 0 at x=0 with zero erase bytes (x-STEP = column 127 on CS2). FRAME_DONE pulses once, BUSY=0, and the bench holds in PAUSE.
- START_X=56, SPR_W=16, STEP=1, RUN=1: each page row is set-page/set-Y(CS1, Y=55); 0x00; 8 ROM bytes (cols 56-63); set-page/set-Y(CS2, Y=0); 8 ROM bytes (cols 64-71). ROM_ADDR for page 1 col 0 = 16.
- START_X=120, DIR=0, 2 frames: second frame draws at x=121. Wrap re-selects CS1 with set-Y 0 at column 0.
- DIR toggled 0->1 at pause end from x=40: next DRAW starts set-Y 39, ends with one 0x00 at col 55. last_dir=1.
- FRAMES=3, 4 pauses: ROM_ADDR frame offset sequence 0, 32, 64, 0, 32.
- Assert RESETN low in the middle of DRAW: all registered outputs take reset values immediately. After release the sequence restarts with 0x3F.
